// File: rtl/reg_init_sequencer_if.sv
// reg_init_sequencer_if: config, sample and downstream-register signals of the init sequencer
interface reg_init_sequencer_if #(
  parameter int XW = 3,
  parameter int YW = 8
);
  logic          cfg_valid, cfg_ready, cfg_sel, cfg_commit, cfg_err;
  logic [YW-1:0] cfg_data;
  logic          in_valid, in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [XW-1:0] x_init, x_in;
  logic [YW-1:0] y_init, y_in;
  logic          dn_rst, out_fresh;
  modport master (
    output cfg_valid, cfg_sel, cfg_data, cfg_commit, in_valid, in_x, in_y,
    input  cfg_ready, cfg_err, in_ready, x_init, y_init, dn_rst, x_in, y_in, out_fresh
  );
  modport slave (
    input  cfg_valid, cfg_sel, cfg_data, cfg_commit, in_valid, in_x, in_y,
    output cfg_ready, cfg_err, in_ready, x_init, y_init, dn_rst, x_in, y_in, out_fresh
  );
endinterface

// File: rtl/reg_init_sequencer.sv
// reg_init_sequencer: staged/atomic init-value commit with timed dn_rst pulse and a sample FIFO
module reg_init_sequencer #(
  parameter int            XW         = 3,
  parameter int            YW         = 8,
  parameter logic [XW-1:0] X_RST      = '0,
  parameter logic [YW-1:0] Y_RST      = '0,
  parameter int            RST_CYCLES = 2,
  parameter int            DEPTH      = 4
) (
  input logic clk,
  input logic rst,
  reg_init_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, APPLY, PULSE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [XW-1:0]    stg_x;
  logic [YW-1:0]    stg_y;
  logic             dirty_x, dirty_y;
  logic [XW+YW-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic             wr_x, wr_y, go, push, pop, empty, full;
  // cfg_ready is only high in IDLE, so accepted writes imply IDLE
  assign wr_x  = bus.cfg_valid && bus.cfg_ready && !bus.cfg_sel;
  assign wr_y  = bus.cfg_valid && bus.cfg_ready && bus.cfg_sel;
  assign go    = state == IDLE && bus.cfg_commit && (dirty_x || wr_x) && (dirty_y || wr_y);
  assign empty = wp == rp;
  assign full  = wp == {~rp[AW], rp[AW-1:0]};
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && state != PULSE;
  assign bus.in_ready = !full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= PULSE;
      cnt           <= CW'(RST_CYCLES - 1);
      bus.dn_rst    <= 1'b1;
      bus.cfg_ready <= 1'b0;
      bus.cfg_err   <= 1'b0;
      bus.x_init    <= X_RST;
      bus.y_init    <= Y_RST;
      stg_x         <= '0;
      stg_y         <= '0;
      dirty_x       <= 1'b0;
      dirty_y       <= 1'b0;
    end else begin
      bus.cfg_err <= state == IDLE && bus.cfg_commit && !go;
      if (wr_x) begin
        stg_x   <= bus.cfg_data[XW-1:0];
        dirty_x <= 1'b1;
      end
      if (wr_y) begin
        stg_y   <= bus.cfg_data;
        dirty_y <= 1'b1;
      end
      case (state)
        IDLE: if (go) begin
          state         <= APPLY;
          bus.cfg_ready <= 1'b0;
        end
        APPLY: begin
          bus.x_init <= stg_x;
          bus.y_init <= stg_y;
          dirty_x    <= 1'b0;
          dirty_y    <= 1'b0;
          state      <= PULSE;
          cnt        <= CW'(RST_CYCLES - 1);
          bus.dn_rst <= 1'b1;
        end
        PULSE: if (cnt == '0) begin
          state         <= IDLE;
          bus.dn_rst    <= 1'b0;
          bus.cfg_ready <= 1'b1;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {bus.in_x, bus.in_y};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp            <= '0;
      rp            <= '0;
      bus.x_in      <= '0;
      bus.y_in      <= '0;
      bus.out_fresh <= 1'b0;
    end else begin
      bus.out_fresh <= pop;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        {bus.x_in, bus.y_in} <= mem[rp[AW-1:0]];
        rp                   <= rp + 1'b1;
      end
    end
endmodule

// File: doc/reg_init_sequencer.md
Name: reg_init_sequencer

Overview:
- Sits directly upstream of the init-capable register stage.
- Supplies that stage with its non-literal reset values (`x_init`, `y_init`), its synchronous reset strobe (`dn_rst`) and its run-time data (`x_in`, `y_in`).
- Config writes are staged, then committed atomically; a commit re-initialises downstream via a timed `dn_rst` pulse.
- Run-time samples pass through a small FIFO, which is frozen while `dn_rst` is asserted.

Parameters:
- XW, 3, width of the x field
- YW, 8, width of the y field; must satisfy YW >= XW
- X_RST, 0, value of `x_init` after async reset
- Y_RST, 0, value of `y_init` after async reset
- RST_CYCLES, 2, number of cycles `dn_rst` stays high per pulse; must be >= 1
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when `cfg_valid` && `cfg_ready`
- cfg_sel  in  1  0 = x field, 1 = y field
- cfg_data  in  YW  write data; the x field uses bits [XW-1:0]
- cfg_commit  in  1  one-cycle commit request
- cfg_err  out  1  one-cycle pulse: commit rejected
- in_valid  in  1  sample valid
- in_ready  out  1  FIFO not full
- in_x  in  XW  sample x
- in_y  in  YW  sample y
- x_init  out  XW  downstream reset value for x
- y_init  out  YW  downstream reset value for y
- dn_rst  out  1  downstream synchronous reset, active-high
- x_in  out  XW  downstream x data
- y_in  out  YW  downstream y data
- out_fresh  out  1  x_in/y_in updated this cycle

Behaviour:
- Async reset (`rst` = 0) sets:
  - `x_init` = X_RST, `y_init` = Y_RST
  - staged regs = 0, both dirty bits = 0
  - FIFO empty
  - `x_in` = 0, `y_in` = 0, `out_fresh` = 0, `cfg_err` = 0
  - `dn_rst` = 1, state = PULSE, pulse counter = RST_CYCLES-1
- After `rst` releases, `dn_rst` stays high for exactly RST_CYCLES further clock edges, then drops.
- FSM states:
  - IDLE: `cfg_ready` = 1, `dn_rst` = 0.
  - APPLY: lasts one cycle. Copies staged values to `x_init`/`y_init` (registered, visible the next cycle) and clears both dirty bits. `cfg_ready` = 0, `dn_rst` = 0. Next state is PULSE with counter = RST_CYCLES-1.
  - PULSE: `dn_rst` = 1, `cfg_ready` = 0. Counter decrements each cycle; at 0 the next state is IDLE.
- Config writes (IDLE only): an accepted write to `cfg_sel` = 0 stores `cfg_data[XW-1:0]` and sets dirty_x; `cfg_sel` = 1 stores `cfg_data` and sets dirty_y. Rewriting a field before commit overwrites it.
- Commit in IDLE:
  - with dirty_x && dirty_y → APPLY.
  - otherwise → `cfg_err` pulses on the next cycle, state stays IDLE and staged values are kept.
- Commit in APPLY or PULSE is ignored and produces no `cfg_err`.
- Write and commit in the same IDLE cycle: the write lands in staging first, and the commit evaluates the dirty bits including that write. If the write completes the pair, APPLY uses the new data.
- `x_init`/`y_init` change only in APPLY; they are stable for the whole PULSE, so downstream samples the new values while `dn_rst` = 1.
- FIFO:
  - Push when `in_valid` && `in_ready`; `in_ready` = !full.
  - Pop when !empty && state != PULSE.
  - A pop registers the head into `x_in`/`y_in` with `out_fresh` = 1 the next cycle; otherwise `x_in`/`y_in` hold and `out_fresh` = 0.
  - Push and pop in the same cycle are both allowed: on full, a simultaneous pop does not raise `in_ready` in the same cycle.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally; full/empty are derived from the MSB compare.
  - Minimum latency from push to `x_in` update is 2 cycles (write, then pop register).
- Pushes are accepted during PULSE; the FIFO contents are preserved across a commit.
- An async reset mid-operation restores all reset values immediately and discards FIFO contents.

Test Plan:
- Reset with RST_CYCLES = 2 → `dn_rst` = 1 during reset and for 2 edges after release; `x_init` = 0, `y_init` = 0.
- Write x = 5, y = 0xA3, then commit → APPLY, then `x_init` = 5 and `y_init` = 0xA3 stable while `dn_rst` is high for 2 cycles, then IDLE with `cfg_ready` = 1.
- Write only y = 0x11, then commit → `cfg_err` pulses 1 cycle, `x_init`/`y_init` unchanged, `dn_rst` stays 0. A later x write plus commit succeeds.
- Same-cycle x write (3) and commit with y already dirty → the commit succeeds with `x_init` = 3.
- Push 4 samples (1,0x10)…(4,0x40) with DEPTH = 4 → `in_ready` = 0 after the 4th un-popped push. Pop order is 1..4 with `out_fresh` pulses, and `x_in` holds 4 afterwards.
- Commit while the FIFO holds 2 entries → no pops or `out_fresh` during PULSE. Entries emerge in order starting the cycle after `dn_rst` falls, with none lost.
